// File: rtl/conv2d_stream_cfg_if.sv
// Stream, kernel-config and mode signals of the 3x3 convolution block.
// master drives pixels/config; slave is the convolution engine.
interface conv2d_stream_cfg_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  cfg_we;
    logic [3:0]            cfg_addr;
    logic [DATA_WIDTH-1:0] cfg_wdata;
    logic                  stride2;
    logic                  relu_en;
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  busy;
    logic                  valid_out;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_last;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata,
        output stride2, relu_en, valid_in, i_data,
        input  busy, valid_out, o_data, o_last
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata,
        input  stride2, relu_en, valid_in, i_data,
        output busy, valid_out, o_data, o_last
    );
endinterface

// File: rtl/conv2d_stream_cfg.sv
// Streaming 3x3 same-padded convolution, Q-format with saturation,
// optional ReLU and stride-2 decimation, runtime-loadable kernel.
module conv2d_stream_cfg #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int WIDTH      = 7,
    parameter int HEIGHT     = 7,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+4
) (
    input logic                clk,
    input logic                rst,
    conv2d_stream_cfg_if.slave bus
);
    localparam int NPIX  = WIDTH*HEIGHT;
    localparam int NSTEP = NPIX + WIDTH + 1;
    localparam int SRLEN = 2*WIDTH + 3;
    localparam int CW    = $clog2(NSTEP + 1);
    localparam int RW    = $clog2(HEIGHT + 1);
    localparam int CLW   = $clog2(WIDTH + 1);
    localparam int PW    = 2*DATA_WIDTH;

    localparam logic [CW-1:0]  FILL_END = CW'(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_PIX = CW'(NPIX - 1);
    localparam logic [CW-1:0]  LAST_STP = CW'(NSTEP - 1);
    localparam logic [RW-1:0]  R_LAST   = RW'(HEIGHT - 1);
    localparam logic [RW-1:0]  R_LAST2  = RW'(((HEIGHT - 1) / 2) * 2);
    localparam logic [CLW-1:0] C_LAST   = CLW'(WIDTH - 1);
    localparam logic [CLW-1:0] C_LAST2  = CLW'(((WIDTH - 1) / 2) * 2);

    localparam logic signed [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1 << FRAC_BITS);
    localparam logic signed [DATA_WIDTH-1:0] RES_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] RES_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0]  SAT_HI  = ACC_WIDTH'(RES_MAX);
    localparam logic signed [ACC_WIDTH-1:0]  SAT_LO  = ACC_WIDTH'(RES_MIN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_FLUSH,
        S_DRAIN
    } state_e;

    state_e                         state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [RW-1:0]                  row_q, row_d;
    logic [CLW-1:0]                 col_q, col_d;
    logic signed [DATA_WIDTH-1:0]   sr_q [SRLEN];
    logic signed [DATA_WIDTH-1:0]   sr_d [SRLEN];
    logic signed [DATA_WIDTH-1:0]   ksh_q [9];
    logic signed [DATA_WIDTH-1:0]   ksh_d [9];
    logic signed [DATA_WIDTH-1:0]   kact_q [9];
    logic signed [DATA_WIDTH-1:0]   kact_d [9];
    logic                           str2_q, str2_d;
    logic                           relu_q, relu_d;
    logic signed [PW-1:0]           prod_q [9];
    logic signed [PW-1:0]           prod_d [9];
    logic                           m_vld_q, m_vld_d;
    logic                           m_last_q, m_last_d;
    logic                           m_tok_q, m_tok_d;
    logic                           m_tlast_q, m_tlast_d;
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic                           s_vld_q, s_vld_d;
    logic                           s_last_q, s_last_d;
    logic                           s_tok_q, s_tok_d;
    logic                           s_tlast_q, s_tlast_d;
    logic signed [DATA_WIDTH-1:0]   out_q, out_d;
    logic                           o_vld_q, o_vld_d;
    logic                           o_last_q, o_last_d;
    logic                           o_tlast_q, o_tlast_d;

    logic                           step;
    logic                           trig;
    logic                           emit;
    logic                           pad;
    logic [CW-1:0]                  idx;
    logic signed [DATA_WIDTH-1:0]   pix;
    logic signed [ACC_WIDTH-1:0]    shr;
    logic signed [DATA_WIDTH-1:0]   res;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        col_d     = col_q;
        sr_d      = sr_q;
        ksh_d     = ksh_q;
        kact_d    = kact_q;
        str2_d    = str2_q;
        relu_d    = relu_q;
        step      = 1'b0;
        pix       = '0;
        pad       = 1'b0;
        idx       = (state_q == S_IDLE) ? '0 : cnt_q;

        for (int k = 0; k < 9; k++) begin
            if (bus.cfg_we && bus.cfg_addr == 4'(k)) begin
                ksh_d[k] = bus.cfg_wdata;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.valid_in) begin
                    step    = 1'b1;
                    pix     = bus.i_data;
                    kact_d  = ksh_d;
                    str2_d  = bus.stride2;
                    relu_d  = bus.relu_en;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (bus.valid_in) begin
                    step = 1'b1;
                    pix  = bus.i_data;
                    if (cnt_q == FILL_END) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (bus.valid_in) begin
                    step = 1'b1;
                    pix  = bus.i_data;
                    if (cnt_q == LAST_PIX) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                step = 1'b1;
                if (cnt_q == LAST_STP) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (o_tlast_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (step) begin
            cnt_d = idx + 1'b1;
            sr_d[0] = pix;
            for (int i = 1; i < SRLEN; i++) begin
                sr_d[i] = sr_q[i-1];
            end
        end

        // Output (row_q,col_q) is centred WIDTH+1 steps behind the newest pixel
        trig = step && (idx >= FILL_END);
        emit = trig && (!str2_q || (!row_q[0] && !col_q[0]));
        m_tok_d   = trig;
        m_tlast_d = trig && (idx == LAST_STP);
        m_vld_d   = emit;
        m_last_d  = emit && (str2_q ? (row_q == R_LAST2 && col_q == C_LAST2)
                                    : (row_q == R_LAST && col_q == C_LAST));

        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                pad = (i == 0 && row_q == '0) || (i == 2 && row_q == R_LAST) ||
                      (j == 0 && col_q == '0) || (j == 2 && col_q == C_LAST);
                prod_d[i*3+j] = pad ? '0 :
                    PW'(kact_q[i*3+j]) * PW'(sr_d[(2-i)*WIDTH + (2-j)]);
            end
        end

        if (trig) begin
            if (col_q == C_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        acc_d = '0;
        for (int k = 0; k < 9; k++) begin
            acc_d = acc_d + ACC_WIDTH'(prod_q[k]);
        end
        s_vld_d   = m_vld_q;
        s_last_d  = m_last_q;
        s_tok_d   = m_tok_q;
        s_tlast_d = m_tlast_q;

        shr = acc_q >>> FRAC_BITS;
        if (shr > SAT_HI) begin
            res = RES_MAX;
        end else if (shr < SAT_LO) begin
            res = RES_MIN;
        end else begin
            res = shr[DATA_WIDTH-1:0];
        end
        if (relu_q && res[DATA_WIDTH-1]) begin
            res = '0;
        end
        out_d     = s_vld_q ? res : out_q;
        o_vld_d   = s_vld_q;
        o_last_d  = s_last_q;
        o_tlast_d = s_tok_q && s_tlast_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            str2_q    <= 1'b0;
            relu_q    <= 1'b0;
            m_vld_q   <= 1'b0;
            m_last_q  <= 1'b0;
            m_tok_q   <= 1'b0;
            m_tlast_q <= 1'b0;
            acc_q     <= '0;
            s_vld_q   <= 1'b0;
            s_last_q  <= 1'b0;
            s_tok_q   <= 1'b0;
            s_tlast_q <= 1'b0;
            out_q     <= '0;
            o_vld_q   <= 1'b0;
            o_last_q  <= 1'b0;
            o_tlast_q <= 1'b0;
            for (int i = 0; i < SRLEN; i++) begin
                sr_q[i] <= '0;
            end
            for (int k = 0; k < 9; k++) begin
                ksh_q[k]  <= (k == 4) ? ONE : '0;
                kact_q[k] <= (k == 4) ? ONE : '0;
                prod_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            col_q     <= col_d;
            sr_q      <= sr_d;
            ksh_q     <= ksh_d;
            kact_q    <= kact_d;
            str2_q    <= str2_d;
            relu_q    <= relu_d;
            prod_q    <= prod_d;
            m_vld_q   <= m_vld_d;
            m_last_q  <= m_last_d;
            m_tok_q   <= m_tok_d;
            m_tlast_q <= m_tlast_d;
            acc_q     <= acc_d;
            s_vld_q   <= s_vld_d;
            s_last_q  <= s_last_d;
            s_tok_q   <= s_tok_d;
            s_tlast_q <= s_tlast_d;
            out_q     <= out_d;
            o_vld_q   <= o_vld_d;
            o_last_q  <= o_last_d;
            o_tlast_q <= o_tlast_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.valid_out = o_vld_q;
    assign bus.o_data    = out_q;
    assign bus.o_last    = o_last_q;
endmodule

// File: tb/tb_conv2d_stream_cfg.sv
// Scoreboard bench for conv2d_stream_cfg on a 4x4 frame with
// directed kernels, padding, saturation, ReLU, stride-2, gaps and reset.
module tb_conv2d_stream_cfg;
    localparam int DW = 16;
    localparam int W  = 4;
    localparam int H  = 4;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        int            c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    exp_t e;
    logic [DW-1:0] pix_a [16];
    logic [DW-1:0] exp_a [16];
    bit   s2_cur;

    conv2d_stream_cfg_if #(.DATA_WIDTH(DW)) bus ();

    conv2d_stream_cfg #(
        .DATA_WIDTH(DW),
        .FRAC_BITS (8),
        .WIDTH     (W),
        .HEIGHT    (H),
        .ACC_WIDTH (2*DW+4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h @cyc %0d", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst && bus.valid_out) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out got=%0h want=none @cyc %0d", bus.o_data, cyc);
            end else begin
                e = sb.pop_front();
                chk("o_data", 32'(bus.o_data), 32'(e.d));
                chk("o_last", 32'(bus.o_last), 32'(e.l));
                chk("latency_cyc", cyc, e.c);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int p, input int tcyc);
        exp_t x;
        int r;
        int c;
        r = p / W;
        c = p % W;
        if (!s2_cur || (r % 2 == 0 && c % 2 == 0)) begin
            x.d = exp_a[p];
            x.l = (p == (s2_cur ? 10 : 15));
            x.c = tcyc + 3;
            sb.push_back(x);
        end
    endtask

    task automatic cfg_write(input int addr, input logic [DW-1:0] val);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 4'(addr);
        bus.cfg_wdata = val;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.busy || sb.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        chk("frame_done_timeout", 32'(n >= 200), 0);
        tick();
    endtask

    task automatic send_frame(input bit s2, input bit relu, input bit gaps,
                              input int ctap, input logic [DW-1:0] cval);
        int t15;
        s2_cur      = s2;
        bus.stride2 = s2;
        bus.relu_en = relu;
        t15 = 0;
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                bus.valid_in = 1'b0;
                repeat (g) tick();
            end
            bus.valid_in = 1'b1;
            bus.i_data   = pix_a[i];
            if (i == 0 && ctap >= 0) begin
                bus.cfg_we    = 1'b1;
                bus.cfg_addr  = 4'(ctap);
                bus.cfg_wdata = cval;
            end
            if (i >= W + 1) push(i - W - 1, cyc);
            t15 = cyc;
            tick();
            bus.cfg_we = 1'b0;
            if (i == 0) chk("busy_in_frame", 32'(bus.busy), 1);
        end
        bus.valid_in = 1'b0;
        for (int k = 0; k <= W; k++) push(16 - W - 1 + k, t15 + 1 + k);
        wait_idle();
    endtask

    initial begin
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
        bus.stride2   = 1'b0;
        bus.relu_en   = 1'b0;
        bus.valid_in  = 1'b0;
        bus.i_data    = '0;
        s2_cur        = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_valid_out", 32'(bus.valid_out), 0);
        chk("rst_o_last", 32'(bus.o_last), 0);
        chk("rst_o_data", 32'(bus.o_data), 0);
        rst = 1'b1;
        tick();

        // identity kernel from reset, ramp
        for (int i = 0; i < 16; i++) begin
            pix_a[i] = DW'(i);
            exp_a[i] = DW'(i);
        end
        send_frame(1'b0, 1'b0, 1'b0, -1, '0);

        // all-ones kernel, all-ones pixels: 4/6/9 taps inside the frame
        for (int k = 0; k < 9; k++) cfg_write(k, 16'h0100);
        for (int i = 0; i < 16; i++) pix_a[i] = 16'h0100;
        exp_a = '{16'd1024, 16'd1536, 16'd1536, 16'd1024,
                  16'd1536, 16'd2304, 16'd2304, 16'd1536,
                  16'd1536, 16'd2304, 16'd2304, 16'd1536,
                  16'd1024, 16'd1536, 16'd1536, 16'd1024};
        send_frame(1'b0, 1'b0, 1'b0, -1, '0);

        // positive saturation, then negative saturation clamped by ReLU
        for (int k = 0; k < 9; k++) cfg_write(k, 16'h7FFF);
        for (int i = 0; i < 16; i++) begin
            pix_a[i] = 16'h7FFF;
            exp_a[i] = 16'h7FFF;
        end
        send_frame(1'b0, 1'b0, 1'b0, -1, '0);
        for (int i = 0; i < 16; i++) begin
            pix_a[i] = 16'h8000;
            exp_a[i] = 16'h0000;
        end
        send_frame(1'b0, 1'b1, 1'b0, -1, '0);

        // k[1][2]=1: out(r,c)=in(r,c+1), right column padded; random gaps
        for (int k = 0; k < 9; k++) cfg_write(k, (k == 5) ? 16'h0100 : 16'h0000);
        for (int i = 0; i < 16; i++) pix_a[i] = DW'(i);
        exp_a = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd5, 16'd6, 16'd7, 16'd0,
                  16'd9, 16'd10, 16'd11, 16'd0, 16'd13, 16'd14, 16'd15, 16'd0};
        send_frame(1'b0, 1'b0, 1'b1, -1, '0);

        // k[2][1]=1 written in the frame-start cycle: out(r,c)=in(r+1,c)
        cfg_write(5, 16'h0000);
        for (int i = 0; i < 16; i++) exp_a[i] = (i < 12) ? DW'(i + 4) : 16'd0;
        send_frame(1'b0, 1'b0, 1'b0, 7, 16'h0100);

        // abort after 6 pixels
        for (int i = 0; i < 6; i++) begin
            bus.valid_in = 1'b1;
            bus.i_data   = DW'(i + 100);
            tick();
        end
        bus.valid_in = 1'b0;
        rst = 1'b0;
        tick();
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_valid_out", 32'(bus.valid_out), 0);
        tick();
        chk("abort_valid_out2", 32'(bus.valid_out), 0);
        chk("abort_o_data", 32'(bus.o_data), 0);
        rst = 1'b1;
        tick();

        // reset restored identity kernel; stride-2 decimation
        for (int i = 0; i < 16; i++) begin
            pix_a[i] = DW'(i);
            exp_a[i] = DW'(i);
        end
        send_frame(1'b1, 1'b0, 1'b0, -1, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
